// File: rtl/ps2_keyboard_pkg.sv
// Shared scancode constants, decoder state encoding and frame check for the PS/2 keyboard receiver.
package ps2_keyboard_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [3:0] LAST_BIT = 4'd10;

    typedef enum logic {
        S_MAKE  = 1'b0,
        S_BREAK = 1'b1
    } dec_state_t;

    // Frame layout: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
    function automatic logic frame_ok(input logic [10:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1]);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous received-byte FIFO; a push while full succeeds only when a pop frees a slot that cycle.
module ps2_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the raw bus, frames and checks bytes, buffers them and decodes make/break.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic [7:0] press_cnt,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    clk_sync;
    logic [2:0]    data_sync;
    logic          fall_p0;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic [10:0]   frame_sr_p0;
    logic          frame_vld_p1;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    rd_byte;
    dec_state_t    state;

    // Stage p0: synchronizers and falling-edge detect on the PS/2 clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign fall_p0 = clk_sync[2] && !clk_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            timer        <= '0;
            frame_vld_p1 <= 1'b0;
        end else begin
            frame_vld_p1 <= 1'b0;
            if (fall_p0) begin
                timer <= '0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt      <= '0;
                    frame_vld_p1 <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned so the next start bit realigns.
                if (timer == TIMER_MAX) begin
                    bit_cnt <= '0;
                    timer   <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fall_p0) frame_sr_p0 <= {data_sync[2], frame_sr_p0[10:1]};
    end

    // Stage p1: frame check, FIFO push and error/overflow flags.
    assign push = frame_vld_p1 && frame_ok(frame_sr_p0);
    assign pop  = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= frame_vld_p1 && !frame_ok(frame_sr_p0);
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    ps2_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (frame_sr_p0[8:1]),
        .rd_data (rd_byte),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Stage p2: make/break decoder fed by one popped byte per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_MAKE;
            key_code  <= 8'h00;
            key_valid <= 1'b0;
            press_cnt <= 8'h00;
        end else if (pop) begin
            case (state)
                S_MAKE: begin
                    if (rd_byte == SC_BREAK) begin
                        state <= S_BREAK;
                    end else if (rd_byte != SC_EXT) begin
                        if (!key_valid || rd_byte != key_code) press_cnt <= press_cnt + 8'd1;
                        key_code  <= rd_byte;
                        key_valid <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rd_byte == key_code) begin
                        key_code  <= 8'h00;
                        key_valid <= 1'b0;
                    end
                    state <= S_MAKE;
                end
                default: state <= S_MAKE;
            endcase
        end
    end

endmodule
